// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, decoded state flags and
// instruction opcodes that scale with the instruction register width.
package jtag_pkg;

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_e;

   // tlr_next looks one edge ahead so instr is already IDCODE on arrival in TLR.
   typedef struct packed {
      logic tlr_next;
      logic cap_dr;
      logic sh_dr;
      logic upd_dr;
      logic cap_ir;
      logic sh_ir;
      logic upd_ir;
   } tap_flags_t;

   localparam int unsigned OP_EXTEST = 0;
   localparam int unsigned OP_SAMPLE = 1;
   localparam int unsigned OP_IDCODE = 2;
   localparam int unsigned OP_INTEST = 3;
   localparam int unsigned OP_USER   = 4;

   localparam logic [1:0] IR_CAPTURE = 2'b01;

   function automatic logic [31:0] op_val(input logic [31:0] op, input int unsigned w);
      logic [31:0] mask;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return op & mask;
   endfunction

   function automatic logic [31:0] bypass_op(input int unsigned w);
      return op_val(32'hFFFF_FFFF, w);
   endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Pin-side and core-side signals of the TAP, grouped for the controller and its driver.
interface jtag_tap_ctrl_if #(
   parameter int unsigned IR_W   = 4,
   parameter int unsigned USER_W = 8
);
   // No handshake: TMS/TDI are sampled on every rising TCK, and TDO carries data only while TDO_EN is high.
   logic              TMS;
   logic              TDI;
   logic              TDO;
   logic              TDO_EN;
   logic              bsr_tdo;
   logic              bsr_capture;
   logic              bsr_shift;
   logic              bsr_update;
   logic              bsr_mode;
   logic [USER_W-1:0] user_capture_data;
   logic [USER_W-1:0] user_update_data;
   logic              user_update_stb;
   logic [IR_W-1:0]   instr;
   logic [3:0]        tap_state;

   modport master (
      output TMS, TDI, bsr_tdo, user_capture_data,
      input  TDO, TDO_EN, bsr_capture, bsr_shift, bsr_update, bsr_mode,
             user_update_data, user_update_stb, instr, tap_state
   );

   modport slave (
      input  TMS, TDI, bsr_tdo, user_capture_data,
      output TDO, TDO_EN, bsr_capture, bsr_shift, bsr_update, bsr_mode,
             user_update_data, user_update_stb, instr, tap_state
   );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP controller, advanced by TMS on rising TCK, plus the
// decoded state flags the register paths act on.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck_i,
   input  logic       trst_ni,
   input  logic       tms_i,
   output tap_state_e state_o,
   output tap_flags_t flags_o
);

   tap_state_e state_q;
   tap_state_e state_d;

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) state_q <= TLR;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:      state_d = tms_i ? TLR    : RTI;
         RTI:      state_d = tms_i ? SEL_DR : RTI;
         SEL_DR:   state_d = tms_i ? SEL_IR : CAP_DR;
         CAP_DR:   state_d = tms_i ? EX1_DR : SH_DR;
         SH_DR:    state_d = tms_i ? EX1_DR : SH_DR;
         EX1_DR:   state_d = tms_i ? UPD_DR : PAUSE_DR;
         PAUSE_DR: state_d = tms_i ? EX2_DR : PAUSE_DR;
         EX2_DR:   state_d = tms_i ? UPD_DR : SH_DR;
         UPD_DR:   state_d = tms_i ? SEL_DR : RTI;
         SEL_IR:   state_d = tms_i ? TLR    : CAP_IR;
         CAP_IR:   state_d = tms_i ? EX1_IR : SH_IR;
         SH_IR:    state_d = tms_i ? EX1_IR : SH_IR;
         EX1_IR:   state_d = tms_i ? UPD_IR : PAUSE_IR;
         PAUSE_IR: state_d = tms_i ? EX2_IR : PAUSE_IR;
         EX2_IR:   state_d = tms_i ? UPD_IR : SH_IR;
         UPD_IR:   state_d = tms_i ? SEL_DR : RTI;
         default:  state_d = TLR;
      endcase

      flags_o          = '0;
      flags_o.tlr_next = (state_d == TLR);
      flags_o.cap_dr   = (state_q == CAP_DR);
      flags_o.sh_dr    = (state_q == SH_DR);
      flags_o.upd_dr   = (state_q == UPD_DR);
      flags_o.cap_ir   = (state_q == CAP_IR);
      flags_o.sh_ir    = (state_q == SH_IR);
      flags_o.upd_ir   = (state_q == UPD_IR);
   end

   assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP block: instruction register, bypass/IDCODE/user data registers,
// boundary-chain strobes and the falling-edge TDO driver.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int unsigned IR_W       = 4,
   parameter int unsigned USER_W     = 8,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input logic            TCK,
   input logic            TRSTn,
   jtag_tap_ctrl_if.slave jif
);

   localparam logic [IR_W-1:0] OPC_EXTEST = IR_W'(op_val(OP_EXTEST, IR_W));
   localparam logic [IR_W-1:0] OPC_SAMPLE = IR_W'(op_val(OP_SAMPLE, IR_W));
   localparam logic [IR_W-1:0] OPC_IDCODE = IR_W'(op_val(OP_IDCODE, IR_W));
   localparam logic [IR_W-1:0] OPC_INTEST = IR_W'(op_val(OP_INTEST, IR_W));
   localparam logic [IR_W-1:0] OPC_USER   = IR_W'(op_val(OP_USER, IR_W));
   localparam logic [IR_W-1:0] IR_CAP_VAL = IR_W'(IR_CAPTURE);

   tap_state_e state;
   tap_flags_t fl;

   jtag_tap_fsm u_fsm (
      .tck_i   (TCK),
      .trst_ni (TRSTn),
      .tms_i   (jif.TMS),
      .state_o (state),
      .flags_o (fl)
   );

   logic [IR_W-1:0]   instr_q,    instr_d;
   logic [IR_W-1:0]   ir_sr_q,    ir_sr_d;
   logic              byp_q,      byp_d;
   logic [31:0]       id_sr_q,    id_sr_d;
   logic [USER_W-1:0] user_sr_q,  user_sr_d;
   logic [USER_W-1:0] user_upd_q, user_upd_d;
   logic              user_stb_q, user_stb_d;
   logic              tdo_q,      tdo_d;
   logic              tdo_en_q,   tdo_en_d;

   logic sel_bsr, sel_id, sel_user, sel_byp, mode, dr_so;

   // Anything not explicitly decoded, including all-ones, falls through to bypass.
   always_comb begin
      sel_bsr  = 1'b0;
      sel_id   = 1'b0;
      sel_user = 1'b0;
      mode     = 1'b0;
      if (instr_q == OPC_EXTEST || instr_q == OPC_INTEST) begin
         sel_bsr = 1'b1;
         mode    = 1'b1;
      end else if (instr_q == OPC_SAMPLE) begin
         sel_bsr = 1'b1;
      end else if (instr_q == OPC_IDCODE) begin
         sel_id = 1'b1;
      end else if (instr_q == OPC_USER) begin
         sel_user = 1'b1;
      end
      sel_byp = ~(sel_bsr | sel_id | sel_user);
   end

   always_comb begin
      instr_d    = instr_q;
      ir_sr_d    = ir_sr_q;
      byp_d      = byp_q;
      id_sr_d    = id_sr_q;
      user_sr_d  = user_sr_q;
      user_upd_d = user_upd_q;
      user_stb_d = 1'b0;

      if (fl.tlr_next)    instr_d = OPC_IDCODE;
      else if (fl.upd_ir) instr_d = ir_sr_q;

      if (fl.cap_ir)     ir_sr_d = IR_CAP_VAL;
      else if (fl.sh_ir) ir_sr_d = IR_W'({jif.TDI, ir_sr_q} >> 1);

      if (fl.cap_dr) begin
         if (sel_byp)  byp_d     = 1'b0;
         if (sel_id)   id_sr_d   = IDCODE_VAL;
         if (sel_user) user_sr_d = jif.user_capture_data;
      end else if (fl.sh_dr) begin
         if (sel_byp)  byp_d     = jif.TDI;
         if (sel_id)   id_sr_d   = 32'({jif.TDI, id_sr_q} >> 1);
         if (sel_user) user_sr_d = USER_W'({jif.TDI, user_sr_q} >> 1);
      end

      if (fl.upd_dr && sel_user) begin
         user_upd_d = user_sr_q;
         user_stb_d = 1'b1;
      end
   end

   always_ff @(posedge TCK or negedge TRSTn) begin
      if (!TRSTn) begin
         instr_q    <= OPC_IDCODE;
         ir_sr_q    <= '0;
         byp_q      <= 1'b0;
         id_sr_q    <= IDCODE_VAL;
         user_sr_q  <= '0;
         user_upd_q <= '0;
         user_stb_q <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         ir_sr_q    <= ir_sr_d;
         byp_q      <= byp_d;
         id_sr_q    <= id_sr_d;
         user_sr_q  <= user_sr_d;
         user_upd_q <= user_upd_d;
         user_stb_q <= user_stb_d;
      end
   end

   always_comb begin
      dr_so = byp_q;
      if (sel_bsr)       dr_so = jif.bsr_tdo;
      else if (sel_id)   dr_so = id_sr_q[0];
      else if (sel_user) dr_so = user_sr_q[0];

      tdo_d = 1'b0;
      if (fl.sh_ir)      tdo_d = ir_sr_q[0];
      else if (fl.sh_dr) tdo_d = dr_so;
      tdo_en_d = fl.sh_ir | fl.sh_dr;
   end

   // Falling-edge launch gives the external capture a full half period of setup.
   always_ff @(negedge TCK or negedge TRSTn) begin
      if (!TRSTn) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign jif.TDO              = tdo_q;
   assign jif.TDO_EN           = tdo_en_q;
   assign jif.bsr_capture      = fl.cap_dr & sel_bsr;
   assign jif.bsr_shift        = fl.sh_dr & sel_bsr;
   assign jif.bsr_update       = fl.upd_dr & sel_bsr;
   assign jif.bsr_mode         = mode;
   assign jif.user_update_data = user_upd_q;
   assign jif.user_update_stb  = user_stb_q;
   assign jif.instr            = instr_q;
   assign jif.tap_state        = state;

endmodule
